// File: rtl/fsk_rx_ctrl.sv
// fsk_rx_ctrl: receive sequencer and half-duplex channel arbiter for fsk_dem.
// Hunts a sync word on bit-window strobes, assembles length + payload bytes
// MSB-first and hands payload out over a one-entry valid/ready buffer.
// Optional feature macro: FSK_RX_CHKSUM_EN adds a trailing XOR checksum byte.
module fsk_rx_ctrl #(
    parameter int unsigned        WIN_LEN   = 16,
    parameter int unsigned        SYNC_W    = 16,
    parameter logic [SYNC_W-1:0]  SYNC_WORD = 16'hA5C3,
    parameter int unsigned        MAX_LEN   = 32,
    parameter int unsigned        GUARD_CYC = 32
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic       tx_req,
    input  logic       tx_done,
    input  logic       sig_reb,
    output logic       trans_enable,
    output logic       tx_grant,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned WCW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int unsigned GCW = $clog2(GUARD_CYC + 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_TX,
        S_GUARD,
        S_HUNT,
        S_LEN,
        S_DATA
`ifdef FSK_RX_CHKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    state_t             w_exit;
    logic [WCW-1:0]     r_win_cnt;
    logic               r_win_seen;
    logic               w_strobe;
    logic               w_trans_en;
    logic               w_busy;
    logic [SYNC_W-1:0]  r_sync;
    logic [6:0]         r_shift;
    logic [7:0]         w_byte;
    logic [2:0]         r_bit_cnt;
    logic               w_last_bit;
    logic [7:0]         r_byte_cnt;
    logic [7:0]         r_len;
    logic [GCW-1:0]     r_guard_cnt;
    logic [7:0]         r_rx_data;
    logic               r_rx_valid;
    logic               r_frame_done;
    logic               r_frame_err;
    logic               w_load;
    logic               w_done;
    logic               w_err;
    logic               w_entry;
`ifdef FSK_RX_CHKSUM_EN
    logic [7:0]         r_chk;
`endif

    assign w_trans_en = (r_state == S_OFF) || (r_state == S_TX) || (r_state == S_GUARD);
`ifdef FSK_RX_CHKSUM_EN
    assign w_busy     = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
`else
    assign w_busy     = (r_state == S_LEN) || (r_state == S_DATA);
`endif
    // The first win_cnt==0 after release is a partial window, so strobes wait for a wrap.
    assign w_strobe   = !w_trans_en && r_win_seen && (r_win_cnt == '0);
    assign w_byte     = {r_shift, sig_reb};
    assign w_last_bit = (r_bit_cnt == 3'd7);
    assign w_exit     = tx_req ? S_TX : S_HUNT;
    assign w_entry    = (w_state_nxt != r_state);

    assign trans_enable = w_trans_en;
    assign tx_grant     = (r_state == S_TX);
    assign rx_busy      = w_busy;
    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign frame_done   = r_frame_done;
    assign frame_err    = r_frame_err;

    // State register.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) r_state <= S_OFF;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode plus frame completion / abort / byte-load decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_OFF: begin
                if (tx_req)     w_state_nxt = S_TX;
                else if (rx_en) w_state_nxt = S_HUNT;
            end
            S_TX: begin
                if (tx_done) w_state_nxt = S_GUARD;
            end
            S_GUARD: begin
                if (r_guard_cnt == GCW'(GUARD_CYC - 1))
                    w_state_nxt = rx_en ? S_HUNT : S_OFF;
            end
            S_HUNT: begin
                // Sync register is compared the cycle after the strobe that shifted it.
                if (tx_req)                   w_state_nxt = S_TX;
                else if (!rx_en)              w_state_nxt = S_OFF;
                else if (r_sync == SYNC_WORD) w_state_nxt = S_LEN;
            end
            S_LEN: begin
                if (!rx_en) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_OFF;
                end else if (w_strobe && w_last_bit) begin
                    if ((w_byte == 8'd0) || (32'(w_byte) > MAX_LEN)) begin
                        w_err       = 1'b1;
                        w_state_nxt = w_exit;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (!rx_en) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_OFF;
                end else if (w_strobe && w_last_bit) begin
                    if (r_rx_valid && !rx_ready) begin
                        w_err       = 1'b1;
                        w_state_nxt = w_exit;
                    end else begin
                        w_load = 1'b1;
                        if ((r_byte_cnt + 8'd1) == r_len) begin
`ifdef FSK_RX_CHKSUM_EN
                            w_state_nxt = S_CHK;
`else
                            w_done      = 1'b1;
                            w_state_nxt = w_exit;
`endif
                        end
                    end
                end
            end
`ifdef FSK_RX_CHKSUM_EN
            S_CHK: begin
                if (!rx_en) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_OFF;
                end else if (w_strobe && w_last_bit) begin
                    if (w_byte == r_chk) w_done = 1'b1;
                    else                 w_err  = 1'b1;
                    w_state_nxt = w_exit;
                end
            end
`endif
            default: w_state_nxt = S_OFF;
        endcase
    end

    // Bit-window counter in lockstep with the demodulator's phase.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_win_cnt  <= '0;
            r_win_seen <= 1'b0;
        end else if (w_trans_en) begin
            r_win_cnt  <= '0;
            r_win_seen <= 1'b0;
        end else if (r_win_cnt == WCW'(WIN_LEN - 1)) begin
            r_win_cnt  <= '0;
            r_win_seen <= 1'b1;
        end else begin
            r_win_cnt  <= r_win_cnt + 1'b1;
        end
    end

    // Sync/shift registers, bit/byte/guard counters, length and checksum capture.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_sync      <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_len       <= '0;
            r_guard_cnt <= '0;
`ifdef FSK_RX_CHKSUM_EN
            r_chk       <= '0;
`endif
        end else begin
            if ((w_state_nxt == S_HUNT) && (r_state != S_HUNT))
                r_sync <= '0;
            else if ((r_state == S_HUNT) && w_strobe)
                r_sync <= {r_sync[SYNC_W-2:0], sig_reb};

            if (w_busy && w_strobe)
                r_shift <= w_byte[6:0];

            if (w_entry)                r_bit_cnt <= '0;
            else if (w_busy && w_strobe) r_bit_cnt <= r_bit_cnt + 3'd1;

            if (w_entry)     r_byte_cnt <= '0;
            else if (w_load) r_byte_cnt <= r_byte_cnt + 8'd1;

            if (w_entry)                  r_guard_cnt <= '0;
            else if (r_state == S_GUARD)  r_guard_cnt <= r_guard_cnt + 1'b1;

            if ((r_state == S_LEN) && w_strobe && w_last_bit)
                r_len <= w_byte;

`ifdef FSK_RX_CHKSUM_EN
            if ((r_state == S_LEN) && w_strobe && w_last_bit)
                r_chk <= w_byte;
            else if (w_load)
                r_chk <= r_chk ^ w_byte;
`endif
        end
    end

    // One-entry output buffer and registered frame status pulses.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (w_load) begin
                r_rx_data  <= w_byte;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            r_frame_done <= w_done;
            r_frame_err  <= w_err;
        end
    end

endmodule
